// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and helpers for the memory request arbiter.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
//
// Contents:
//   port_idx_width(n) - bits needed to hold a port index (minimum 1)
//   mem_req_t         - downstream request payload {addr, we, be, wdata}
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  function automatic int port_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  we;
    logic [MEM_BE_W-1:0]   be;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Purpose: in-order queue of granted port indices awaiting their response.
// Latency: pushed entry visible at data_o one cycle later (when it is the head).
// Backpressure: push ignored while full_o, pop ignored while empty_o.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   push_i, data_i   enqueue a port index
//   pop_i            dequeue the head entry
//   data_o           head entry (valid when !empty_o)
//   full_o, empty_o  registered occupancy flags
module mem_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_en;
  logic             pop_en;

  // Full is taken from the registered count, so a pop in the full cycle
  // only makes room for a push on the following cycle.
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Purpose: round-robin merge of NR_PORTS req/gnt/rvalid requesters onto one memory port.
// Latency: combinational request/grant path; responses routed back in the same cycle.
// Backpressure: stalled winner is locked until mem_gnt_i; no request while MAX_OUTSTANDING in flight.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   port_req_i/addr/we/be/wdata  per-port requests, held until port_gnt_o
//   port_gnt_o, port_rvalid_o    per-port grant / response valid (one-hot or zero)
//   port_rdata_o                 response data shared by all ports
//   mem_req_o ... mem_wdata_o    downstream request and payload
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  downstream handshake and response
//   err_o                        sticky protocol error (only with MEM_ARB_ERR_CHECK_EN)
// Build option: define MEM_ARB_ERR_CHECK_EN to add err_o and protocol checking.
// Payload widths follow mem_arb_pkg::mem_req_t; ADDR_WIDTH/DATA_WIDTH default to match it.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NR_PORTS        = 3,
  parameter int ADDR_WIDTH      = MEM_ADDR_W,
  parameter int DATA_WIDTH      = MEM_DATA_W,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NR_PORTS-1:0]              port_req_i,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0]   port_addr_i,
  input  logic [NR_PORTS-1:0]              port_we_i,
  input  logic [NR_PORTS*DATA_WIDTH/8-1:0] port_be_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0]   port_wdata_i,
  output logic [NR_PORTS-1:0]              port_gnt_o,
  output logic [NR_PORTS-1:0]              port_rvalid_o,
  output logic [DATA_WIDTH-1:0]            port_rdata_o,
  output logic                             mem_req_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic                             mem_we_o,
  output logic [DATA_WIDTH/8-1:0]          mem_be_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic                             mem_gnt_i,
  input  logic                             mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i
`ifdef MEM_ARB_ERR_CHECK_EN
  ,
  output logic                             err_o
`endif
);

  localparam int             IDX_W      = port_idx_width(NR_PORTS);
  localparam int             BE_W       = DATA_WIDTH / 8;
  localparam logic [IDX_W:0] NR_PORTS_W = (IDX_W+1)'(NR_PORTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_PORTS - 1);

  logic [IDX_W-1:0] rr_ptr_q;
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx_q;

  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;
  logic [IDX_W-1:0] winner;
  logic             winner_vld;
  mem_req_t         sel_req;

  logic             handshake;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] fifo_head;

  // Round-robin search starting at rr_ptr. cand is one bit wider than an
  // index so rr_ptr + i cannot overflow before the wrap subtraction.
  always_comb begin
    cand    = '0;
    arb_idx = '0;
    arb_vld = 1'b0;
    for (int i = 0; i < NR_PORTS; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= NR_PORTS_W) cand = cand - NR_PORTS_W;
      if (!arb_vld && port_req_i[cand[IDX_W-1:0]]) begin
        arb_vld = 1'b1;
        arb_idx = cand[IDX_W-1:0];
      end
    end
  end

  // A stalled request keeps ownership of the downstream port so the payload
  // seen by memory cannot change between req and gnt.
  assign winner     = lock_q ? lock_idx_q : arb_idx;
  assign winner_vld = lock_q || arb_vld;

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_req.addr  = port_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_req.we    = port_we_i[i];
        sel_req.be    = port_be_i[i*BE_W +: BE_W];
        sel_req.wdata = port_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign mem_req_o   = winner_vld && !fifo_full;
  assign mem_addr_o  = sel_req.addr;
  assign mem_we_o    = sel_req.we;
  assign mem_be_o    = sel_req.be;
  assign mem_wdata_o = sel_req.wdata;

  assign handshake = mem_req_o && mem_gnt_i;
  // An rvalid with nothing outstanding has no owner and is dropped.
  assign pop       = mem_rvalid_i && !fifo_empty;

  always_comb begin
    port_gnt_o    = '0;
    port_rvalid_o = '0;
    if (handshake) port_gnt_o[winner]       = 1'b1;
    if (pop)       port_rvalid_o[fifo_head] = 1'b1;
  end

  assign port_rdata_o = mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (handshake) begin
      rr_ptr_q <= (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
      lock_q   <= 1'b0;
    end else if (mem_req_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= winner;
    end
  end

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (winner),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef MEM_ARB_ERR_CHECK_EN
  mem_req_t held_req_q;
  logic     err_q;

  // Snapshot the payload when the lock is first taken; any later difference
  // (or a dropped req) while locked is a requester protocol violation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      held_req_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (mem_req_o && !mem_gnt_i && !lock_q) held_req_q <= sel_req;
      if ((mem_rvalid_i && fifo_empty) ||
          (lock_q && (!port_req_i[lock_idx_q] || sel_req != held_req_q))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`endif

endmodule
